// File: rtl/pdm_tone_meter.sv
// Integrate-and-dump PDM decimator followed by a hysteresis zero-crossing
// tracker that reports tone period, peak amplitude and an in-range flag.
module pdm_tone_meter #(
  parameter int unsigned DEC_LOG2 = 8,
  parameter logic [15:0] HYST     = 16'd2048,
  parameter logic [15:0] MAX_PER  = 16'd4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PDM,
  input  logic [15:0] per_lo,
  input  logic [15:0] per_hi,
  input  logic [15:0] amp_min,
  output logic [15:0] sample,
  output logic        sample_vld,
  output logic [15:0] period,
  output logic [15:0] peak_amp,
  output logic        meas_vld,
  output logic        in_range,
  output logic        no_tone
);

  localparam int unsigned N  = 1 << DEC_LOG2;
  localparam int unsigned OW = DEC_LOG2 + 1;
  localparam int unsigned SH = 15 - DEC_LOG2;
  localparam int unsigned SW = 18;
  localparam logic signed [SW-1:0] N_S   = SW'(N);
  localparam logic signed [SW-1:0] S_MAX = 18'sd32767;

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] MEAS  = 2'd2;

  // Decimator: the bit on the last window cycle is folded in combinationally
  logic [DEC_LOG2-1:0]  win_cnt;
  logic [OW-1:0]        ones;
  logic [OW-1:0]        ones_tot_c;
  logic signed [SW-1:0] diff_c;
  logic signed [SW-1:0] scaled_c;
  logic                 last_c;

  assign last_c     = &win_cnt;
  assign ones_tot_c = ones + OW'(PDM);
  assign diff_c     = $signed(SW'({ones_tot_c, 1'b0})) - N_S;
  assign scaled_c   = diff_c <<< SH;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt    <= '0;
      ones       <= '0;
      sample     <= '0;
      sample_vld <= 1'b0;
    end else begin
      win_cnt    <= win_cnt + DEC_LOG2'(1);
      sample_vld <= last_c;
      if (last_c) begin
        ones   <= '0;
        sample <= (scaled_c > S_MAX) ? 16'h7fff : 16'(scaled_c);
      end else begin
        ones <= ones_tot_c;
      end
    end
  end

  // Crossing tracker; pol = 1 means POS
  logic [1:0]         state, state_nxt;
  logic               pol, pol_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic [15:0]        pk, pk_nxt;
  logic [15:0]        cnt_inc_c, abs_c, pk_max_c;
  logic signed [16:0] s_ext_c, hyst_ext_c;
  logic               pos_c, neg_c, meas_c, tmo_c;

  assign s_ext_c    = $signed({sample[15], sample});
  assign hyst_ext_c = $signed({1'b0, HYST});
  assign pos_c      = s_ext_c > hyst_ext_c;
  assign neg_c      = s_ext_c < -hyst_ext_c;
  assign abs_c      = (sample == 16'h8000) ? 16'h7fff :
                      (sample[15] ? (~sample + 16'd1) : sample);
  assign cnt_inc_c  = cnt + 16'd1;
  assign pk_max_c   = (abs_c > pk) ? abs_c : pk;

  always_comb begin
    state_nxt = state;
    pol_nxt   = pol;
    cnt_nxt   = cnt;
    pk_nxt    = pk;
    meas_c    = 1'b0;
    tmo_c     = 1'b0;
    if (sample_vld) begin
      case (state)
        SYNC: begin
          if (neg_c) begin
            state_nxt = WAIT1;
            pol_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end
        WAIT1: begin
          if (pos_c) begin
            state_nxt = MEAS;
            pol_nxt   = 1'b1;
            cnt_nxt   = '0;
            pk_nxt    = '0;
          end else if (cnt_inc_c == MAX_PER) begin
            tmo_c     = 1'b1;
            state_nxt = SYNC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end
        MEAS: begin
          // A crossing on the timeout sample takes priority over the timeout
          if (pos_c && !pol) begin
            meas_c  = 1'b1;
            pol_nxt = 1'b1;
            cnt_nxt = '0;
            pk_nxt  = '0;
          end else if (cnt_inc_c == MAX_PER) begin
            tmo_c     = 1'b1;
            state_nxt = SYNC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc_c;
            pk_nxt  = pk_max_c;
            if (pos_c) begin
              pol_nxt = 1'b1;
            end else if (neg_c) begin
              pol_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      pol      <= 1'b0;
      cnt      <= '0;
      pk       <= '0;
      period   <= '0;
      peak_amp <= '0;
      meas_vld <= 1'b0;
      in_range <= 1'b0;
      no_tone  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pol      <= pol_nxt;
      cnt      <= cnt_nxt;
      pk       <= pk_nxt;
      meas_vld <= meas_c;
      if (meas_c) begin
        period   <= cnt_inc_c;
        peak_amp <= pk_max_c;
        in_range <= (cnt_inc_c >= per_lo) && (cnt_inc_c <= per_hi) &&
                    (pk_max_c >= amp_min);
        no_tone  <= 1'b0;
      end else if (tmo_c) begin
        no_tone <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_tone_meter.sv
// Scoreboard bench for pdm_tone_meter with a short decimation window (N = 64)
// and MAX_PER = 40 so tone and timeout scenarios stay compact.
module tb_pdm_tone_meter;

  localparam int unsigned DL = 6;
  localparam int NW = 1 << DL;
  localparam logic [15:0] F1 = 16'h7fff;
  localparam logic [15:0] F0 = 16'h8000;
  localparam logic [15:0] SP = 16'h1000;
  localparam logic [15:0] SN = 16'hf000;

  typedef struct {
    logic [15:0] per;
    logic [15:0] pk;
    logic        inr;
  } meas_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pdm = 1'b0;
  logic [15:0] per_lo, per_hi, amp_min;
  logic [15:0] sample, period, peak_amp;
  logic        sample_vld, meas_vld, in_range, no_tone;

  logic [15:0] sq[$];
  meas_t       mq[$];
  meas_t       em;
  logic [15:0] es;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic        prev_svld = 1'b0;
  logic        no_tone_seen = 1'b0;

  pdm_tone_meter #(.DEC_LOG2(DL), .HYST(16'd2048), .MAX_PER(16'd40)) dut (
    .clk(clk), .rst(rst), .PDM(pdm),
    .per_lo(per_lo), .per_hi(per_hi), .amp_min(amp_min),
    .sample(sample), .sample_vld(sample_vld),
    .period(period), .peak_amp(peak_amp), .meas_vld(meas_vld),
    .in_range(in_range), .no_tone(no_tone)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: pulse with empty scoreboard at %0t", nm, $time);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_sample"}, sample, 0);
    check({nm, "_sample_vld"}, sample_vld, 0);
    check({nm, "_period"}, period, 0);
    check({nm, "_peak_amp"}, peak_amp, 0);
    check({nm, "_meas_vld"}, meas_vld, 0);
    check({nm, "_in_range"}, in_range, 0);
    check({nm, "_no_tone"}, no_tone, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse
  always @(negedge clk) begin
    if (mon_en) begin
      if (sample_vld) begin
        if (sq.size() == 0) unexpected("sample_vld");
        else begin
          es = sq.pop_front();
          check("sample", sample, es);
        end
      end
      if (meas_vld) begin
        if (mq.size() == 0) unexpected("meas_vld");
        else begin
          em = mq.pop_front();
          check("meas_lag", prev_svld, 1);
          check("period", period, em.per);
          check("peak_amp", peak_amp, em.pk);
          check("in_range", in_range, em.inr);
          check("no_tone_at_meas", no_tone, 0);
        end
      end
    end
    prev_svld = sample_vld;
  end

  task automatic drive_win(input int n1, input bit alt, input logic [15:0] exp);
    int early = 0;
    sq.push_back(exp);
    for (int i = 0; i < NW; i++) begin
      pdm = alt ? ((i % 2) == 0) : (i < n1);
      @(posedge clk); #1;
      if (i == 0) no_tone_seen = no_tone;
      if (i < NW - 1 && sample_vld) early++;
    end
    check("vld_early", early, 0);
    check("vld_pulse", sample_vld, 1);
  endtask

  task automatic tone(input int n_lo, input int lo1, input logic [15:0] lo_exp,
                      input int n_hi, input int hi1, input logic [15:0] hi_exp,
                      input bit push, input logic [15:0] ep, input logic [15:0] epk,
                      input logic einr);
    for (int w = 0; w < n_lo; w++) drive_win(lo1, 1'b0, lo_exp);
    if (push) mq.push_back('{per: ep, pk: epk, inr: einr});
    for (int w = 0; w < n_hi; w++) drive_win(hi1, 1'b0, hi_exp);
  endtask

  task automatic hyst_win(input int w);
    case (w % 4)
      0:       drive_win(33, 1'b0, 16'h0400);
      1:       drive_win(30, 1'b0, 16'hf800);
      2:       drive_win(34, 1'b0, 16'h0800);
      default: drive_win(31, 1'b0, 16'hfc00);
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    per_lo  = 16'd18;
    per_hi  = 16'd22;
    amp_min = 16'd30000;

    // Reset with random PDM
    repeat (10) begin @(posedge clk); #1; pdm = 1'($urandom); end
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check_zero("reset");
    repeat (2) begin pdm = 1'($urandom); @(posedge clk); #1; end
    rst = 1'b0;

    // Decimator extremes
    drive_win(64, 1'b0, F1);
    drive_win(0, 1'b0, F0);
    drive_win(0, 1'b1, 16'h0000);
    drive_win(48, 1'b0, 16'h4000);
    drive_win(34, 1'b0, 16'h0800);
    do_reset();
    check_zero("reset2");

    // Sub-hysteresis swing after entering WAIT1: no measurement, then timeout
    drive_win(0, 1'b0, F0);
    for (int w = 0; w < 40; w++) hyst_win(w);
    check("hyst_no_tone_early", no_tone_seen, 0);
    hyst_win(40);
    check("hyst_no_tone_set", no_tone_seen, 1);
    do_reset();
    check_zero("reset3");

    // Square tone and threshold variations
    tone(10, 0, F0, 10, 64, F1, 1'b0, 0, 0, 1'b0);
    tone(10, 0, F0, 10, 64, F1, 1'b1, 16'd20, F1, 1'b1);
    per_hi = 16'd19;
    tone(10, 0, F0, 10, 64, F1, 1'b1, 16'd20, F1, 1'b0);
    per_hi = 16'd22;
    tone(8, 0, F0, 10, 64, F1, 1'b1, 16'd18, F1, 1'b1);
    tone(10, 28, SN, 10, 36, SP, 1'b1, 16'd20, F1, 1'b1);
    tone(10, 28, SN, 10, 36, SP, 1'b1, 16'd20, SP, 1'b0);
    amp_min = 16'd4096;
    tone(10, 28, SN, 10, 36, SP, 1'b1, 16'd20, SP, 1'b1);
    amp_min = 16'd30000;
    tone(10, 0, F0, 12, 64, F1, 1'b1, 16'd20, F1, 1'b1);
    tone(11, 0, F0, 10, 64, F1, 1'b1, 16'd23, F1, 1'b0);

    // Hold PDM high until the period counter times out
    for (int w = 0; w < 31; w++) drive_win(64, 1'b0, F1);
    check("tmo_early", no_tone_seen, 0);
    drive_win(64, 1'b0, F1);
    check("tmo_set", no_tone_seen, 1);

    // Recovery, then crossing on the same sample as the timeout
    tone(10, 0, F0, 10, 64, F1, 1'b0, 0, 0, 1'b0);
    check("no_tone_sticky", no_tone, 1);
    tone(10, 0, F0, 10, 64, F1, 1'b1, 16'd20, F1, 1'b1);
    check("no_tone_cleared", no_tone, 0);
    tone(30, 0, F0, 10, 64, F1, 1'b1, 16'd40, F1, 1'b0);
    check("cross_beats_tmo", no_tone, 0);

    // Reset mid-measurement and mid-window
    for (int w = 0; w < 5; w++) drive_win(0, 1'b0, F0);
    for (int i = 0; i < 20; i++) begin pdm = 1'b1; @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_mid");
    rst = 1'b0;
    drive_win(48, 1'b0, 16'h4000);
    tone(10, 0, F0, 10, 64, F1, 1'b0, 0, 0, 1'b0);
    tone(10, 0, F0, 10, 64, F1, 1'b1, 16'd20, F1, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("sample_q_empty", sq.size(), 0);
    check("meas_q_empty", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_tone_meter.md
# pdm_tone_meter

Downstream measurement stage for the Equalizer's class-D outputs. It takes one PDM bitstream (`lft_PDM` or `rght_PDM`) and decimates it back to 16-bit signed samples. It tracks the dominant tone with a hysteresis zero-crossing detector and reports tone period, peak amplitude and an in-range flag once per cycle of the tone. It is used as a synthesizable self-check beside the speaker drivers and as the band-response checker in the equalizer benches.

## Interface
Parameters:
- `DEC_LOG2`, default 8: decimation window is N = 2^DEC_LOG2 clocks; legal range 4..15.
- `HYST`, default 16'd2048: zero-crossing hysteresis threshold, applied to signed sample magnitude.
- `MAX_PER`, default 16'd4000: timeout, in decimated samples, with no rising crossing.

Ports:
- `clk`, in, 1: system clock. One clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `PDM`, in, 1: PDM bitstream, sampled every clk.
- `per_lo`, in, 16: lower in-range period bound, in samples, inclusive.
- `per_hi`, in, 16: upper in-range period bound, in samples, inclusive.
- `amp_min`, in, 16: minimum peak amplitude for in-range, inclusive.
- `sample`, out, 16: signed decimated sample.
- `sample_vld`, out, 1: one-cycle pulse when `sample` updates.
- `period`, out, 16: samples between the last two rising crossings.
- `peak_amp`, out, 16: max |sample| over that interval, 0..32767.
- `meas_vld`, out, 1: one-cycle pulse when `period` and `peak_amp` update.
- `in_range`, out, 1: registered alongside `meas_vld`.
- `no_tone`, out, 1: sticky timeout flag.

## Operation
- **Decimator (integrate-and-dump).**
  - `win_cnt` runs 0..N-1 and `ones` counts the 1s seen in the window (0..N).
  - On the last window cycle, the sample is computed as s = (2·ones − N) << (15 − DEC_LOG2).
  - If s ≥ 32768 it saturates to 32767. The low end is exactly −32768.
  - The accumulator restarts from 0 on the next window with no lost bit.
- **Polarity state machine.** States SYNC, WAIT1, MEAS; it advances only on cycles where a sample is valid.
  - SYNC → WAIT1 on the first sample < −HYST. This sets polarity to NEG.
  - WAIT1 → MEAS on the first NEG→POS transition. This is the first rising crossing.
    - The period counter clears to 0.
    - The peak tracker clears to 0.
  - In MEAS:
    - The period counter increments per sample.
    - The peak tracker keeps max |s|, with |−32768| taken as 32767.
  - Polarity rules:
    - POS is entered when s > +HYST.
    - NEG is entered when s < −HYST.
    - Samples inside ±HYST hold the polarity.
  - On each NEG→POS transition in MEAS:
    - Latch `period` = counter + 1 (the crossing sample counts).
    - Latch `peak_amp` = max including the crossing sample.
    - Compute `in_range` = (per_lo ≤ period ≤ per_hi) && (peak_amp ≥ amp_min).
    - Pulse `meas_vld`.
    - Clear the counter and the peak tracker.
- **Timeout.** If the counter reaches MAX_PER in WAIT1 or MEAS:
  - `no_tone` is set.
  - The state returns to SYNC.
  - No `meas_vld` is generated.
  - The counter also runs in WAIT1, counting from the SYNC exit.
  - `no_tone` clears on the next `meas_vld`.
- **Threshold inputs.** `per_lo`, `per_hi` and `amp_min` are sampled only when a crossing is processed. A change takes effect at the next measurement.
- **Simultaneous events.** If a crossing lands on the same sample the counter hits MAX_PER, the crossing wins: a measurement is reported and there is no timeout.

## Timing
- Reset values:
  - `sample` = 0, `sample_vld` = 0.
  - `period` = 0, `peak_amp` = 0.
  - `meas_vld` = 0, `in_range` = 0, `no_tone` = 0.
  - State = SYNC, `win_cnt` = 0, `ones` = 0.
- Let k = 0 be the first cycle with `rst` low:
  - PDM bits at k = 0..N−1 form the first window.
  - `sample_vld` is high at k = N, then every N cycles.
  - `sample` holds its value between pulses.
- `meas_vld` rises exactly one cycle after the `sample_vld` carrying the crossing sample.
- `period`, `peak_amp` and `in_range` change only in that same cycle and hold until the next measurement.
- `rst` asserted mid-window or mid-measurement returns everything to reset values on the next edge. The partial window is discarded.

## Test plan
- **Reset:** drive random PDM, assert `rst` for 3 cycles → all outputs 0 on the cycle after the first `rst` edge; first `sample_vld` at k = 256.
- **Decimator extremes (N = 256):**
  - PDM all 1 → `sample` = 32767.
  - All 0 → −32768.
  - Alternating 10 → 0.
  - 192 ones per window → 16384.
- **Square tone:** PDM 1 for 2560 clocks then 0 for 2560, repeated; `per_lo` = 18, `per_hi` = 22, `amp_min` = 30000 →
  - First `meas_vld` one cycle after the second rising crossing.
  - `period` = 20, `peak_amp` = 32767, `in_range` = 1.
  - `meas_vld` then pulses every 5120 clocks.
  - With `per_hi` = 19 → `in_range` = 0.
- **Hysteresis:** tone swinging ±1500 (below HYST = 2048) → no `meas_vld`; `no_tone` sets after 4000 samples.
- **Timeout and recovery:**
  - Lock on the square tone, then hold PDM = 1 → `no_tone` = 1 when the counter reaches 4000, state SYNC.
  - Restore the tone → `no_tone` clears at the next `meas_vld`.
- **Reset mid-measurement:** `rst` during MEAS halfway through a period → outputs 0, window restarts. The next valid measurement again requires a full SYNC → WAIT1 → MEAS pass.
